// File: rtl/uart_proc_if.sv
// Handshake bundle between uart_proc and the surrounding RX/TX FIFOs.
// master = processing engine side, slave = FIFO/top-level side.
interface uart_proc_if #(
   parameter int DBIT = 8
);
   logic [1:0]      op_sel;
   logic            tx_full;
   logic            rx_empty;
   logic [DBIT-1:0] r_data;
   logic [DBIT-1:0] w_data;
   logic            rd_uart;
   logic            wr_uart;
   logic            busy;

   modport master (
      input  op_sel, tx_full, rx_empty, r_data,
      output w_data, rd_uart, wr_uart, busy
   );

   modport slave (
      output op_sel, tx_full, rx_empty, r_data,
      input  w_data, rd_uart, wr_uart, busy
   );
endinterface

// File: rtl/uart_proc.sv
// RX FIFO -> op (pass / +K / invert / -K) -> TX FIFO engine, one word in flight.
// Optional UART_PROC_CNT_EN adds a 16-bit pushed-word counter with sync clear.
module uart_proc #(
   parameter int DBIT = 8,
   parameter int K    = 1
) (
   input  logic           clk,
   input  logic           reset,
   uart_proc_if.master    bus
`ifdef UART_PROC_CNT_EN
   ,
   input  logic           cnt_clr,
   output logic [15:0]    word_cnt
`endif
);

   localparam logic [DBIT-1:0] K_W = DBIT'(K);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      POP  = 3'd1,
      CALC = 3'd2,
      WAIT = 3'd3,
      PUSH = 3'd4
   } state_t;

   state_t          state, state_nx;
   logic [DBIT-1:0] data_reg, res_reg, res_nx;
   logic [1:0]      op_reg;
   logic            cap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Moore decode: strobes depend only on the registered state
   always_comb begin
      state_nx    = state;
      cap         = 1'b0;
      bus.rd_uart = 1'b0;
      bus.wr_uart = 1'b0;
      bus.busy    = 1'b1;
      case (state)
         IDLE: begin
            bus.busy = 1'b0;
            if (!bus.rx_empty) begin
               cap      = 1'b1;
               state_nx = POP;
            end
         end
         POP: begin
            bus.rd_uart = 1'b1;
            state_nx    = CALC;
         end
         CALC: state_nx = WAIT;
         WAIT: if (!bus.tx_full) state_nx = PUSH;
         PUSH: begin
            bus.wr_uart = 1'b1;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      case (op_reg)
         2'b00:   res_nx = data_reg;
         2'b01:   res_nx = data_reg + K_W;
         2'b10:   res_nx = ~data_reg;
         default: res_nx = data_reg - K_W;
      endcase
   end

   // op_sel is latched with the word so later changes cannot affect it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_reg <= '0;
         op_reg   <= 2'b00;
         res_reg  <= '0;
      end else begin
         if (cap) begin
            data_reg <= bus.r_data;
            op_reg   <= bus.op_sel;
         end
         if (state == CALC) res_reg <= res_nx;
      end
   end

   assign bus.w_data = res_reg;

`ifdef UART_PROC_CNT_EN
   // clear has priority over a coincident push
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              word_cnt <= '0;
      else if (cnt_clr)        word_cnt <= '0;
      else if (state == PUSH)  word_cnt <= word_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_uart_proc.sv
// Self-checking bench for uart_proc: FIFO-like driver/monitor plus a word-level reference model.
module tb_uart_proc;
   localparam int DBIT = 8;
   localparam int K    = 1;
   localparam int M    = 1 << DBIT;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   uart_proc_if #(.DBIT(DBIT)) ifc ();

`ifdef UART_PROC_CNT_EN
   logic        cnt_clr = 1'b0;
   logic [15:0] word_cnt;
`endif

   uart_proc #(.DBIT(DBIT), .K(K)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (ifc)
`ifdef UART_PROC_CNT_EN
      ,
      .cnt_clr  (cnt_clr),
      .word_cnt (word_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   logic [9:0]      rx_q[$];
   logic [DBIT-1:0] tx_out[$];
   int              exp_q[$];
   int              wr_cyc_q[$];
   int              rd_cnt = 0, wr_cnt = 0, rd_cyc = -1, wr_cyc = -1;
   bit              overlap = 1'b0;
   logic [1:0]      idle_op = 2'b00;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // FIFO model: pops on rd_uart, collects pushes, presents queue head
   initial begin
      ifc.rx_empty = 1'b1;
      ifc.r_data   = '0;
      ifc.op_sel   = 2'b00;
      forever begin
         @(negedge clk);
         if (ifc.rd_uart && ifc.wr_uart) overlap = 1'b1;
         if (ifc.rd_uart) begin
            rd_cnt++;
            rd_cyc = cyc;
            if (rx_q.size() > 0) void'(rx_q.pop_front());
         end
         if (ifc.wr_uart) begin
            wr_cnt++;
            wr_cyc = cyc;
            wr_cyc_q.push_back(cyc);
            tx_out.push_back(ifc.w_data);
         end
         if (rx_q.size() > 0) begin
            ifc.rx_empty = 1'b0;
            ifc.r_data   = rx_q[0][DBIT-1:0];
            ifc.op_sel   = rx_q[0][9:8];
         end else begin
            ifc.rx_empty = 1'b1;
            ifc.op_sel   = idle_op;
         end
      end
   end

   function automatic int model(input int op, input int d);
      case (op)
         0:       return d;
         1:       return (d + K) % M;
         2:       return (M - 1) - d;
         default: return (d - (K % M) + M) % M;
      endcase
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_out(input int n, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (tx_out.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (tx_out.size() >= n) ok = 1'b1;
   endtask

   task automatic clear_logs();
      tx_out.delete();
      exp_q.delete();
      wr_cyc_q.delete();
   endtask

   task automatic test_reset();
      int k;
      bit ok;
      clear_logs();
      #2 reset = 1'b0;
      rx_q.push_back({2'b01, 8'h41});
      repeat (3) tick();
      n_chk++; if (ifc.rd_uart !== 1'b0) $display("FAIL rst_rd: got %b want 0", ifc.rd_uart); else n_pass++;
      n_chk++; if (ifc.wr_uart !== 1'b0) $display("FAIL rst_wr: got %b want 0", ifc.wr_uart); else n_pass++;
      n_chk++; if (ifc.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", ifc.busy); else n_pass++;
      n_chk++; if (ifc.w_data !== 8'h00) $display("FAIL rst_wdata: got %h want 00", ifc.w_data); else n_pass++;
`ifdef UART_PROC_CNT_EN
      n_chk++; if (word_cnt !== 16'h0) $display("FAIL rst_cnt: got %h want 0000", word_cnt); else n_pass++;
`endif
      k = cyc;
      reset = 1'b1;
      wait_out(1, 50, ok);
      n_chk++; if (rd_cyc !== k + 1) $display("FAIL rst_rel_rd_cyc: got %0d want %0d", rd_cyc, k + 1); else n_pass++;
      n_chk++; if (!ok || tx_out[0] !== 8'h42) $display("FAIL rst_rel_data: got %h want 42", ok ? tx_out[0] : 8'hxx); else n_pass++;
   endtask

   task automatic test_ops();
      logic [9:0] stim [5];
      logic [7:0] want [5];
      int c0;
      bit ok;
      stim[0] = {2'b01, 8'h41}; want[0] = 8'h42;
      stim[1] = {2'b01, 8'hFF}; want[1] = 8'h00;
      stim[2] = {2'b10, 8'h5A}; want[2] = 8'hA5;
      stim[3] = {2'b11, 8'h00}; want[3] = 8'hFF;
      stim[4] = {2'b00, 8'h3C}; want[4] = 8'h3C;
      ifc.tx_full = 1'b0;
      for (int i = 0; i < 5; i++) begin
         clear_logs();
         repeat (2) tick();
         rx_q.push_back(stim[i]);
         tick();
         c0 = cyc + 1;
         wait_out(1, 50, ok);
         n_chk++; if (rd_cyc !== c0) $display("FAIL op%0d_rd_cyc: got %0d want %0d", i, rd_cyc, c0); else n_pass++;
         n_chk++; if (wr_cyc !== c0 + 3) $display("FAIL op%0d_wr_cyc: got %0d want %0d", i, wr_cyc, c0 + 3); else n_pass++;
         n_chk++; if (!ok || tx_out[0] !== want[i]) $display("FAIL op%0d_data: got %h want %h", i, ok ? tx_out[0] : 8'hxx, want[i]); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int op, d;
      clear_logs();
      ifc.tx_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         op = $urandom_range(0, 3);
         d  = $urandom_range(0, M - 1);
         rx_q.push_back({op[1:0], d[7:0]});
         exp_q.push_back(model(op, d));
      end
      wait_out(3, 100, ok);
      n_chk++; if (!ok) $display("FAIL b2b_timeout: got %0d words want 3", tx_out.size()); else n_pass++;
      for (int i = 0; i < 3 && ok; i++) begin
         n_chk++; if (int'(tx_out[i]) !== exp_q[i]) $display("FAIL b2b_data%0d: got %h want %h", i, tx_out[i], exp_q[i]); else n_pass++;
      end
      for (int i = 1; i < 3 && ok; i++) begin
         n_chk++; if (wr_cyc_q[i] - wr_cyc_q[i-1] !== 5) $display("FAIL b2b_spacing%0d: got %0d want 5", i, wr_cyc_q[i] - wr_cyc_q[i-1]); else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int c0, rd0, wr0, x;
      bit ok;
      clear_logs();
      repeat (2) tick();
      ifc.tx_full = 1'b1;
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      rx_q.push_back({2'b10, 8'h5A});
      rx_q.push_back({2'b00, 8'h3C});
      tick();
      c0 = cyc + 1;
      while (cyc < c0 + 2) tick();
      repeat (10) tick();
      n_chk++; if (wr_cnt !== wr0) $display("FAIL bp_no_wr: got %0d pushes want %0d", wr_cnt - wr0, 0); else n_pass++;
      n_chk++; if (rd_cnt !== rd0 + 1) $display("FAIL bp_no_rd: got %0d pops want 1", rd_cnt - rd0); else n_pass++;
      n_chk++; if (ifc.busy !== 1'b1) $display("FAIL bp_busy: got %b want 1", ifc.busy); else n_pass++;
      x = cyc;
      ifc.tx_full = 1'b0;
      tick();
      n_chk++; if (wr_cyc !== x + 1) $display("FAIL bp_release_cyc: got %0d want %0d", wr_cyc, x + 1); else n_pass++;
      wait_out(2, 50, ok);
      n_chk++; if (!ok || tx_out[0] !== 8'hA5) $display("FAIL bp_data0: got %h want a5", ok ? tx_out[0] : 8'hxx); else n_pass++;
      n_chk++; if (!ok || tx_out[1] !== 8'h3C) $display("FAIL bp_data1: got %h want 3c", ok ? tx_out[1] : 8'hxx); else n_pass++;
   endtask

   task automatic test_midflight();
      int c0, d;
      bit ok;
      clear_logs();
      repeat (2) tick();
      ifc.tx_full = 1'b0;
      d = $urandom_range(0, M - 1);
      idle_op = 2'b01;
      rx_q.push_back({2'b01, d[7:0]});
      tick();
      c0 = cyc + 1;
      while (cyc < c0) tick();
      idle_op = 2'b10;
      wait_out(1, 50, ok);
      idle_op = 2'b00;
      n_chk++; if (!ok || int'(tx_out[0]) !== model(1, d)) $display("FAIL mid_opchange: got %h want %h", ok ? tx_out[0] : 8'hxx, model(1, d)); else n_pass++;
   endtask

   task automatic test_reset_wait();
      int c0, wr0;
      clear_logs();
      repeat (2) tick();
      ifc.tx_full = 1'b1;
      rx_q.push_back({2'b00, 8'h77});
      tick();
      c0 = cyc + 1;
      while (cyc < c0 + 2) tick();
      wr0 = wr_cnt;
      reset = 1'b0;
      tick();
      n_chk++; if (ifc.busy !== 1'b0) $display("FAIL rw_busy: got %b want 0", ifc.busy); else n_pass++;
      n_chk++; if (ifc.w_data !== 8'h00) $display("FAIL rw_wdata: got %h want 00", ifc.w_data); else n_pass++;
      reset = 1'b1;
      ifc.tx_full = 1'b0;
      repeat (10) tick();
      n_chk++; if (wr_cnt !== wr0) $display("FAIL rw_discard: got %0d pushes want 0", wr_cnt - wr0); else n_pass++;
      n_chk++; if (ifc.busy !== 1'b0) $display("FAIL rw_idle: got %b want 0", ifc.busy); else n_pass++;
   endtask

   task automatic test_random();
      int op, d, rd0, guard;
      clear_logs();
      repeat (2) tick();
      rd0 = rd_cnt;
      overlap = 1'b0;
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 3);
         d  = $urandom_range(0, M - 1);
         rx_q.push_back({op[1:0], d[7:0]});
         exp_q.push_back(model(op, d));
      end
      guard = 0;
      while (tx_out.size() < 40 && guard < 2000) begin
         ifc.tx_full = ($urandom_range(0, 3) == 0);
         tick();
         guard++;
      end
      ifc.tx_full = 1'b0;
      n_chk++; if (tx_out.size() !== 40) $display("FAIL rnd_count: got %0d want 40", tx_out.size()); else n_pass++;
      for (int i = 0; i < 40 && i < tx_out.size(); i++) begin
         n_chk++; if (int'(tx_out[i]) !== exp_q[i]) $display("FAIL rnd_data%0d: got %h want %h", i, tx_out[i], exp_q[i]); else n_pass++;
      end
      n_chk++; if (rd_cnt - rd0 !== 40) $display("FAIL rnd_pops: got %0d want 40", rd_cnt - rd0); else n_pass++;
      n_chk++; if (overlap !== 1'b0) $display("FAIL rnd_rd_wr_overlap: got %b want 0", overlap); else n_pass++;
   endtask

`ifdef UART_PROC_CNT_EN
   task automatic test_counter();
      int c0;
      bit ok;
      clear_logs();
      repeat (2) tick();
      ifc.tx_full = 1'b0;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      n_chk++; if (word_cnt !== 16'd0) $display("FAIL cnt_clear: got %0d want 0", word_cnt); else n_pass++;
      for (int i = 0; i < 3; i++) rx_q.push_back({2'b00, 8'h11});
      wait_out(3, 100, ok);
      tick();
      n_chk++; if (word_cnt !== 16'd3) $display("FAIL cnt_three: got %0d want 3", word_cnt); else n_pass++;
      clear_logs();
      rx_q.push_back({2'b00, 8'h22});
      tick();
      c0 = cyc + 1;
      while (cyc < c0 + 3) tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      n_chk++; if (word_cnt !== 16'd0) $display("FAIL cnt_clr_wins: got %0d want 0", word_cnt); else n_pass++;
      n_chk++; if (tx_out.size() !== 1) $display("FAIL cnt_clr_push: got %0d pushes want 1", tx_out.size()); else n_pass++;
   endtask
`endif

   initial begin
      ifc.tx_full = 1'b0;
      test_reset();
      test_ops();
      test_back_to_back();
      test_backpressure();
      test_midflight();
      test_reset_wait();
      test_random();
`ifdef UART_PROC_CNT_EN
      test_counter();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
